flit_fifo_agilex7: RTL and testbench
====================================

Name: flit_fifo_agilex7

Overview:
- Single-clock, synchronous-read FIFO used as the per-input flit buffer and destination buffer in NoC router input ports.
- Normal (non-show-ahead) mode: q is updated one cycle after an accepted read and holds that value until the next accepted read.
- Upstream flow control is credit-based, so `full` is informational. Overflow and underflow attempts are still safely ignored.
- Memory is inferred RAM/registers. A parameter steers it to MLAB.

Parameters:
- WIDTH, 32: data word width in bits (≥1).
- DEPTH, 2: number of entries (≥2; any integer, need not be a power of two).
- FORCE_MLAB, 1: 1 = storage array carries ramstyle "MLAB" attribute; 0 = tool chooses. No functional effect.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset: synchronous, active-low; clock clk.
- data  input  WIDTH  write data.
- wrreq  input  1  write request.
- rdreq  input  1  read request.
- q  output  WIDTH  read data, registered.
- empty  output  1  no stored entries.
- full  output  1  DEPTH entries stored.
- usedw  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.

Behaviour:
- State: storage array [DEPTH], write pointer, read pointer (each 0..DEPTH-1, wrap DEPTH-1→0), count.
- Reset (rst_n=0 at posedge):
  - pointers=0, count=0, usedw=0, q=0, empty=1, full=0.
  - Storage array is not cleared.
  - Reset has priority over any simultaneous wrreq/rdreq.
  - Reset mid-operation discards all contents.
- Accepted write: wr_ok = wrreq & (~full | rd_ok). Writes data at wptr, then advances wptr.
- Accepted read: rd_ok = rdreq & ~empty. Loads q <= mem[rptr], then advances rptr.
- Read latency:
  - rdreq at edge N (FIFO non-empty) → q shows the oldest word after edge N, i.e. valid during cycle N+1.
  - q holds otherwise, including on ignored reads.
- Count update:
  - count += wr_ok - rd_ok.
  - Simultaneous accepted read and write leaves count unchanged.
- Flags:
  - empty = (count==0), full = (count==DEPTH), usedw = count.
  - All are registered or derived from the registered count, so they reflect state after the last edge.
  - A write into an empty FIFO drops empty on the next cycle (no fall-through).
- Boundary conditions:
  - Read when empty: ignored, no pointer or q change.
  - Write when full without read: ignored, data lost.
  - Write when full with read: both accepted; the read returns the oldest word, the write lands in the freed slot.
  - Write+read when empty: only the write takes effect.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: FIFO_AGX7_PROTOCOL_CHECK_EN.
- When defined: simulation-only checks fire $error on:
  - wrreq while full without rdreq (overflow);
  - rdreq while empty (underflow);
  - X/Z on wrreq/rdreq while rst_n=1.
  - Also counts violations in an internal integer for end-of-test reporting.
- When undefined: checks are absent, and functional behaviour is identical (violations silently ignored).

Test Plan:
- Reset: hold rst_n=0 two cycles with wrreq=rdreq=1 → empty=1, full=0, usedw=0, q=0.
- WIDTH=8, DEPTH=2: write 0xA1 then 0xB2.
  - empty=0 after the first edge; full=1, usedw=2 after the second.
  - rdreq one cycle → q=0xA1 the next cycle; second read → q=0xB2, empty=1.
  - q holds 0xB2 while rdreq=0.
- Full + third write 0xC3 without read → ignored, usedw stays 2; reads return 0xA1, 0xB2 only.
- Full, simultaneous write 0xC3 and read → q=0xA1, usedw=2; next reads give 0xB2, 0xC3 (pointer wrap verified).
- Empty, rdreq=1 with wrreq=1 data 0x55 → q unchanged, usedw=1; next read → q=0x55.
- Assert rst_n=0 while usedw=2 → next cycle empty=1, usedw=0; a subsequent write/read of 0x77 returns 0x77.

Source files
------------

// File: rtl/flit_fifo_agilex7.sv
// ============================================================================
// flit_fifo_agilex7 - single-clock synchronous-read flit FIFO (non-show-ahead)
// Optional macro: FIFO_AGX7_PROTOCOL_CHECK_EN (simulation overflow/underflow/X checks)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flit_fifo_agilex7 #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter int FORCE_MLAB = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data,
  input  logic                       wrreq,
  input  logic                       rdreq,
  output logic [WIDTH-1:0]           q,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     usedw
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rd_word;
  logic             wr_ok, rd_ok;
  logic             empty_w, full_w;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // A read frees a slot in the same edge, so a full FIFO still accepts a paired write
  assign rd_ok = rdreq & ~empty_w;
  assign wr_ok = wrreq & (~full_w | rd_ok);

  generate
    if (FORCE_MLAB != 0) begin : g_mlab
      (* ramstyle = "MLAB" *) logic [WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (rst_n && wr_ok) mem[wptr_q] <= data;
      end
      assign rd_word = mem[rptr_q];
    end else begin : g_auto
      logic [WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (rst_n && wr_ok) mem[wptr_q] <= data;
      end
      assign rd_word = mem[rptr_q];
    end
  endgenerate

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    q_d     = q_q;
    if (wr_ok) wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + PW'(1);
    if (rd_ok) begin
      rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + PW'(1);
      q_d    = rd_word;
    end
    if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
    else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      q_q     <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      q_q     <= q_d;
    end
  end

  assign q     = q_q;
  assign empty = empty_w;
  assign full  = full_w;
  assign usedw = count_q;

`ifdef FIFO_AGX7_PROTOCOL_CHECK_EN
  integer violations_q = 0;

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if ($isunknown(wrreq) || $isunknown(rdreq)) begin
        $error("flit_fifo_agilex7: X/Z on wrreq/rdreq");
        violations_q <= violations_q + 1;
      end else if (wrreq && full_w && !rdreq) begin
        $error("flit_fifo_agilex7: overflow, write dropped");
        violations_q <= violations_q + 1;
      end else if (rdreq && empty_w) begin
        $error("flit_fifo_agilex7: underflow, read ignored");
        violations_q <= violations_q + 1;
      end
    end
  end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_flit_fifo_agilex7.sv
// Directed self-checking bench for flit_fifo_agilex7 (WIDTH=8, DEPTH=2).
`default_nettype none

module tb_flit_fifo_agilex7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       wrreq, rdreq;
  logic [7:0] q;
  logic       empty, full;
  logic [1:0] usedw;

  int n_checks = 0;
  int n_fail   = 0;

  flit_fifo_agilex7 #(.WIDTH(8), .DEPTH(2), .FORCE_MLAB(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .wrreq (wrreq),
    .rdreq (rdreq),
    .q     (q),
    .empty (empty),
    .full  (full),
    .usedw (usedw)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle so outputs reflect the state after the edge
  task automatic tick(input logic w, input logic r, input logic [7:0] d);
    wrreq = w;
    rdreq = r;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tick(1'b1, 1'b1, 8'hFF);
    tick(1'b1, 1'b1, 8'hFF);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full",  32'(full),  32'd0);
    check_eq("rst_usedw", 32'(usedw), 32'd0);
    check_eq("rst_q",     32'(q),     32'h00);
    rst_n = 1'b1;

    // Basic fill and drain
    tick(1'b1, 1'b0, 8'hA1);
    check_eq("wr1_empty", 32'(empty), 32'd0);
    check_eq("wr1_usedw", 32'(usedw), 32'd1);
    tick(1'b1, 1'b0, 8'hB2);
    check_eq("wr2_full",  32'(full),  32'd1);
    check_eq("wr2_usedw", 32'(usedw), 32'd2);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("rd1_q",     32'(q),     32'hA1);
    check_eq("rd1_usedw", 32'(usedw), 32'd1);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("rd2_q",     32'(q),     32'hB2);
    check_eq("rd2_empty", 32'(empty), 32'd1);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    check_eq("hold_q",    32'(q),     32'hB2);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("undf_q",     32'(q),     32'hB2);
    check_eq("undf_usedw", 32'(usedw), 32'd0);

    // Overflow without read is dropped
    tick(1'b1, 1'b0, 8'hA1);
    tick(1'b1, 1'b0, 8'hB2);
    tick(1'b1, 1'b0, 8'hC3);
    check_eq("ovf_usedw", 32'(usedw), 32'd2);
    check_eq("ovf_full",  32'(full),  32'd1);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("ovf_rd1",   32'(q),     32'hA1);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("ovf_rd2",   32'(q),     32'hB2);
    check_eq("ovf_empty", 32'(empty), 32'd1);

    // Full with simultaneous write/read; then drain across the pointer wrap
    tick(1'b1, 1'b0, 8'hA1);
    tick(1'b1, 1'b0, 8'hB2);
    tick(1'b1, 1'b1, 8'hC3);
    check_eq("frw_q",     32'(q),     32'hA1);
    check_eq("frw_usedw", 32'(usedw), 32'd2);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("frw_rd1",   32'(q),     32'hB2);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("frw_rd2",   32'(q),     32'hC3);
    check_eq("frw_empty", 32'(empty), 32'd1);

    // Empty with simultaneous write/read: only the write lands
    tick(1'b1, 1'b1, 8'h55);
    check_eq("erw_q",     32'(q),     32'hC3);
    check_eq("erw_usedw", 32'(usedw), 32'd1);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("erw_rd",    32'(q),     32'h55);
    check_eq("erw_empty", 32'(empty), 32'd1);

    // Reset mid-operation discards contents
    tick(1'b1, 1'b0, 8'h11);
    tick(1'b1, 1'b0, 8'h22);
    check_eq("pre_rst_usedw", 32'(usedw), 32'd2);
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    check_eq("mid_rst_empty", 32'(empty), 32'd1);
    check_eq("mid_rst_usedw", 32'(usedw), 32'd0);
    check_eq("mid_rst_full",  32'(full),  32'd0);
    check_eq("mid_rst_q",     32'(q),     32'h00);
    tick(1'b1, 1'b0, 8'h77);
    tick(1'b0, 1'b1, 8'h00);
    check_eq("post_rst_q",     32'(q),     32'h77);
    check_eq("post_rst_empty", 32'(empty), 32'd1);
    tick(1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
